board_manager: RTL
==================

# board_manager

Connect‑4 board and referee datapath: holds the 7×6 grid, accepts piece drops, flags full or out‑of‑range columns, and scans for four‑in‑a‑row or a full board after every placement. Sits directly upstream of the game FSM. Its `invalid_column` and `game_status` outputs drive that FSM's `invalid_column` and `in_game_status` inputs. The FSM's player turn drives `player` here.

## Interface
- `COLS`, 7: board columns (column index 0..6).
- `ROWS`, 6: board rows (row 0 = bottom).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears board, heights, status and state.
- `drop`  in  1  single-cycle drop request; sampled only in IDLE.
- `column`  in  3  target column of the drop.
- `player`  in  1  piece owner: 0 = P1, 1 = P2; sampled with `drop`.
- `invalid_column`  out  1  one-cycle pulse: the drop was rejected (column full or `column` > 6).
- `busy`  out  1  high from the cycle after an accepted drop through REPORT.
- `done`  out  1  one-cycle pulse in REPORT; `game_status` is valid from that cycle.
- `game_status`  out  2  00 playing, 01 win, 10 tie (board full), 11 unused.
- `winner`  out  1  owner of the winning piece; meaningful only when `game_status` = 01.
- `rd_col`  in  3  display read column.
- `rd_row`  in  3  display read row.
- `rd_cell`  out  2  combinational cell read: 00 empty, 01 P1, 10 P2; 00 for out-of-range indices.

## Operation
- Storage is 42 cells × 2 bits, plus a 3-bit height per column and a 6-bit placed-piece counter.
- **Reset values:** all cells 00, heights 0, counter 0, `game_status` 00, `winner` 0, `invalid_column` 0, `busy` 0, `done` 0, state IDLE.
- **States:** IDLE, PLACE, SCAN, REPORT, OVER.
- **IDLE**
  - On `drop` with `column` > 6 or height[column] = 6: pulse `invalid_column` next cycle, stay in IDLE; the board is unchanged.
  - On any other `drop`: latch column, player and row = height[column]; go to PLACE.
- **PLACE:** write the cell, increment the height and the counter, clear the scan registers, go to SCAN.
- **SCAN**
  - Axes are checked in order: horizontal, vertical, diagonal /, diagonal \.
  - For each axis, step offset k = −3..+3 from the placed cell, one cell per cycle.
  - A 3-bit run counter increments when the cell is in range and owned by the latched player; otherwise it resets to 0.
  - Win is set when the run reaches 4.
  - After the last axis, go to REPORT. Scanning does not stop early; latency is fixed.
- **REPORT:** pulse `done`.
  - win → `game_status` 01, `winner` = latched player, go to OVER.
  - No win and counter = 42 → `game_status` 10, go to OVER.
  - Otherwise → `game_status` stays 00, go to IDLE.
- **OVER:** `drop` is ignored, with no `invalid_column` pulse. The only exit is `reset`.
- `drop` asserted while `busy` is ignored, with no `invalid_column` pulse.
- `player` is not checked for alternation; the FSM owns turn order.
- Win has priority over tie when the 42nd piece completes a line.

## Timing
- Drop sampled at edge 0. A rejected drop pulses `invalid_column` in cycle 1.
- Accepted drop, with diagonals compiled in:
  - PLACE in cycle 1.
  - SCAN in cycles 2–29 (28 cycles).
  - REPORT/`done` in cycle 30.
  - Next drop is accepted from cycle 31.
- `game_status` and `winner` change only in the REPORT cycle or on reset; they hold otherwise.
- `rd_cell` reflects a write from the cycle after PLACE.
- `reset` asserted mid-SCAN: board and outputs clear immediately (asynchronously); no `done` is produced.

## Configuration
- `BOARD_DIAG_EN` defined:
  - all four axes are scanned;
  - SCAN is 28 cycles and `done` arrives in cycle 30.
- `BOARD_DIAG_EN` undefined:
  - only horizontal and vertical axes are scanned, so diagonal lines never win;
  - SCAN is 14 cycles and `done` arrives in cycle 16.
- Everything else is identical.

## Test plan
- **Reset, then one drop:** `drop`, col 3, P1 → `busy` in cycles 1–30, `done` in cycle 30, `game_status` 00, `rd_cell`(3,0) = 01, height 1.
- **Full and out-of-range columns:** six alternating drops into col 0, then a seventh → `invalid_column` pulse in cycle 1, no `busy`, board unchanged. `column` = 7 → same result.
- **Vertical win:** P1 drops col 2 four times, with P2 drops in col 5 between them → the fourth P1 drop gives `done`, `game_status` 01, `winner` 0, state OVER. A further `drop` → no response.
- **Diagonal win:** P2 builds / from (0,0) to (3,3).
  - `BOARD_DIAG_EN` set → `game_status` 01, `winner` 1, `done` in cycle 30.
  - `BOARD_DIAG_EN` unset → `game_status` 00, `done` in cycle 16.
- **Tie:** fill all 42 cells in a known no-line pattern → the final `done` gives `game_status` 10.
- **Reset mid-operation:** assert `reset` in cycle 10 of SCAN → all outputs 0, all cells 00. A new drop is accepted after `reset` drops.

Source files
------------

// File: rtl/board_manager.sv
// Connect-4 board store and referee: accepts drops, rejects bad columns and scans the
// placed cell's lines for four-in-a-row. Defining BOARD_DIAG_EN adds the two diagonal axes.
module board_manager #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drop,
    input  logic [2:0] column,
    input  logic       player,
    output logic       invalid_column,
    output logic       busy,
    output logic       done,
    output logic [1:0] game_status,
    output logic       winner,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_cell
);
    localparam int CELLS = COLS * ROWS;
    localparam logic [2:0] COLS_U = 3'(COLS);
    localparam logic [2:0] ROWS_U = 3'(ROWS);
    localparam logic [5:0] CELLS_U = 6'(CELLS);
    localparam logic signed [4:0] COLS_S = $signed(5'(COLS));
    localparam logic signed [4:0] ROWS_S = $signed(5'(ROWS));
`ifdef BOARD_DIAG_EN
    localparam logic [1:0] LAST_AXIS = 2'd3;
`else
    localparam logic [1:0] LAST_AXIS = 2'd1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_PLACE, S_SCAN, S_REPORT, S_OVER} state_t;

    state_t     r_state;
    logic [1:0] r_board [CELLS];
    logic [2:0] r_height [COLS];
    logic [5:0] r_count;
    logic [2:0] r_col;
    logic [2:0] r_row;
    logic [2:0] r_k;
    logic [2:0] r_run;
    logic [1:0] r_axis;
    logic       r_player;
    logic       r_win;

    function automatic logic [5:0] cell_idx(input logic [2:0] c, input logic [2:0] r);
        return 6'(r) * 6'(COLS) + 6'(c);
    endfunction

    logic              w_drop_ok;
    logic [1:0]        w_mine;
    logic signed [4:0] w_off;
    logic signed [4:0] w_scan_col;
    logic signed [4:0] w_scan_row;
    logic              w_scan_in;
    logic              w_scan_hit;
    logic [2:0]        w_run_base;
    logic [2:0]        w_run_next;
    logic              w_win_next;

    assign w_drop_ok = (column < COLS_U) && (r_height[column] != ROWS_U);
    assign w_mine    = r_player ? 2'b10 : 2'b01;
    assign w_off     = $signed({2'b00, r_k}) - 5'sd3;

    // Axis 0 horizontal, 1 vertical, 2 rising diagonal, 3 falling diagonal.
    always_comb begin
        w_scan_col = $signed({2'b00, r_col});
        w_scan_row = $signed({2'b00, r_row});
        case (r_axis)
            2'd0:    w_scan_col = w_scan_col + w_off;
            2'd1:    w_scan_row = w_scan_row + w_off;
            2'd2: begin
                w_scan_col = w_scan_col + w_off;
                w_scan_row = w_scan_row + w_off;
            end
            default: begin
                w_scan_col = w_scan_col + w_off;
                w_scan_row = w_scan_row - w_off;
            end
        endcase
    end

    assign w_scan_in  = (w_scan_col >= 5'sd0) && (w_scan_col < COLS_S) &&
                        (w_scan_row >= 5'sd0) && (w_scan_row < ROWS_S);
    assign w_scan_hit = w_scan_in &&
                        (r_board[cell_idx(w_scan_col[2:0], w_scan_row[2:0])] == w_mine);
    // The run restarts at the first step of every axis so runs never chain across axes.
    assign w_run_base = (r_k == 3'd0) ? 3'd0 : r_run;
    assign w_run_next = w_scan_hit ? w_run_base + 3'd1 : 3'd0;
    assign w_win_next = r_win | (w_run_next >= 3'd4);

    always_comb begin
        rd_cell = 2'b00;
        if (rd_col < COLS_U && rd_row < ROWS_U)
            rd_cell = r_board[cell_idx(rd_col, rd_row)];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) r_board[i] <= 2'b00;
            for (int i = 0; i < COLS; i++) r_height[i] <= 3'd0;
            r_state        <= S_IDLE;
            r_count        <= 6'd0;
            r_col          <= 3'd0;
            r_row          <= 3'd0;
            r_k            <= 3'd0;
            r_run          <= 3'd0;
            r_axis         <= 2'd0;
            r_player       <= 1'b0;
            r_win          <= 1'b0;
            invalid_column <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            game_status    <= 2'b00;
            winner         <= 1'b0;
        end else begin
            invalid_column <= 1'b0;
            done           <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (drop) begin
                        if (!w_drop_ok) begin
                            invalid_column <= 1'b1;
                        end else begin
                            r_col    <= column;
                            r_row    <= r_height[column];
                            r_player <= player;
                            busy     <= 1'b1;
                            r_state  <= S_PLACE;
                        end
                    end
                end
                S_PLACE: begin
                    r_board[cell_idx(r_col, r_row)] <= w_mine;
                    r_height[r_col] <= r_height[r_col] + 3'd1;
                    r_count  <= r_count + 6'd1;
                    r_axis   <= 2'd0;
                    r_k      <= 3'd0;
                    r_run    <= 3'd0;
                    r_win    <= 1'b0;
                    r_state  <= S_SCAN;
                end
                S_SCAN: begin
                    r_run <= w_run_next;
                    r_win <= w_win_next;
                    if (r_k == 3'd6) begin
                        r_k <= 3'd0;
                        if (r_axis == LAST_AXIS) begin
                            // Results are registered here so they are valid in the REPORT cycle.
                            r_state <= S_REPORT;
                            done    <= 1'b1;
                            if (w_win_next) begin
                                game_status <= 2'b01;
                                winner      <= r_player;
                            end else if (r_count == CELLS_U) begin
                                game_status <= 2'b10;
                            end
                        end else begin
                            r_axis <= r_axis + 2'd1;
                        end
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_REPORT: begin
                    busy    <= 1'b0;
                    r_state <= (game_status == 2'b00) ? S_IDLE : S_OVER;
                end
                default: ;
            endcase
        end
    end

endmodule
